pid_mc_core: RTL and testbench
==============================

Name: pid_mc_core

Overview:
- Time-multiplexed, multi-channel successor to the single-channel PID controller.
- One shared multiplier serves NUM_CH independent loops, with per-channel gains, limits, integrator and previous-error state.
- Gains are signed fixed-point with FRAC_BITS fraction bits.
- Sits between the AXI register bank (config writes) and the sensor/actuator samplers (valid/ready sample stream in, result pulse out).

Parameters:
VAL_LENGTH, 32, width of all signed values, gains and limits
NUM_CH, 4, number of PID channels (>=1)
CH_W, 2, channel index width, >= clog2(NUM_CH) (minimum 1)
FRAC_BITS, 8, fractional bits of kp/ki/kd (gain 1.0 = 2^FRAC_BITS)

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe
cfg_ch  in  CH_W  config target channel
cfg_sel  in  4  register select: 0 target, 1 kp, 2 ki, 3 kd, 4 int_max, 5 int_min, 6 dif_max, 7 dif_min, 8 uk_max, 9 uk_min, 15 clear channel state
cfg_data  in  VAL_LENGTH  signed write data
cfg_ready  out  1  write accepted this cycle when cfg_we=1
sample_valid  in  1  sample request
sample_ch  in  CH_W  sample channel
current_value  in  VAL_LENGTH  signed measured value
sample_ready  out  1  core can accept a sample
out_valid  out  1  one-cycle result pulse
out_ch  out  CH_W  channel of result
pid_out  out  VAL_LENGTH  signed saturated controller output

Behaviour:
- Reset (async, sys_rst_n=0): all config registers, integ[] and e_prev[] = 0; FSM to IDLE; out_valid=0, out_ch=0, pid_out=0.
- Outputs are registered.
- FSM states:
  - IDLE -> ERR on sample accept.
  - ERR: e = sat(target-cur); integ_n = clamp(integ+e, int_min, int_max); dif = clamp(e-e_prev, dif_min, dif_max). Writes back integ and e_prev = e.
  - ERR -> MUL_P -> MUL_I -> MUL_D: one multiply per state (kp*e, ki*integ_n, kd*dif), accumulated at 2*VAL_LENGTH+2 bits.
  - MUL_D -> SAT -> IDLE.
  - SAT: acc >>> FRAC_BITS (arithmetic, floor toward -inf), clamp to [uk_min, uk_max], saturate to VAL_LENGTH. Registers pid_out and out_ch; out_valid=1 for exactly one cycle.
- Latency: out_valid is high in the cycle after the 5th rising edge following the accepting edge.
- Throughput: one sample per 6 cycles.
- sample_ready = (state==IDLE) && !cfg_we; samples are accepted only in that case.
- sample_ch >= NUM_CH is consumed without effect: no state change, no out_valid.
- Config:
  - cfg_ready = (state==IDLE).
  - cfg_we and sample_valid together in IDLE: the config write wins; the sample waits (ready low).
  - Writes while busy are not accepted; the master holds cfg_we.
  - cfg_sel 15 zeroes integ and e_prev of cfg_ch.
  - Unused cfg_sel codes and cfg_ch >= NUM_CH are accepted and ignored.
- Clamp rule (all clamps): apply max first, then min. If min>max, result = min.
- Intermediate e and differences are computed at VAL_LENGTH+1 bits, then saturated to VAL_LENGTH before use.
- Reset mid-computation: the result is discarded, no out_valid, and all state is cleared.
- Channels are fully isolated: a computation touches only its own channel's integ/e_prev.

Decomposition:
- Package pid_mc_pkg: cfg_sel codes, FSM state encoding, clamp/saturate functions.
- Sub-module pid_sat: parameterised signed clamp (value, min, max, widths), instantiated for int, dif, uk and width saturation.
- Config and state arrays stay in pid_mc_core.

Test Plan:
1. Reset: assert sys_rst_n=0 mid-computation -> out_valid never pulses; pid_out=0; sample_ready=1 the cycle after release.
2. Proportional (ch0): target=1357, kp=256, ki=kd=0, uk [-5000,5000], cur=1000 -> pid_out=357, out_ch=0, out_valid at accept+5 edges; same with uk_min=500 -> 500.
3. Integral windup (ch1): ki=768, kp=kd=0, int [-50,50], target=100, cur=0, three samples -> 150, 150, 150. Then a cfg_sel 15 clear followed by cur=130 (e=-30) -> -90.
4. Derivative (ch2): kd=512, others 0, dif [-20,20], target=0; cur=0, -5, -100 -> 0, 10, 40.
5. Isolation/handshake: interleave ch1 and ch3 samples, ch3 integ unaffected. cfg_we and sample_valid asserted together in IDLE -> config applied, sample accepted the next cycle. sample_valid held during busy -> not accepted until IDLE.
6. Rounding/limits: kp=128, target=0, cur=3 -> pid_out=-2. Set uk_min=10, uk_max=5 -> output 10. sample_ch=NUM_CH -> no out_valid.

Source files
------------

// File: rtl/pid_mc_pkg.sv
// rtl/pid_mc_pkg.sv - shared codes, FSM encoding and clamp/saturate helpers for pid_mc_core
package pid_mc_pkg;

  localparam logic [3:0] SEL_TARGET  = 4'd0;
  localparam logic [3:0] SEL_KP      = 4'd1;
  localparam logic [3:0] SEL_KI      = 4'd2;
  localparam logic [3:0] SEL_KD      = 4'd3;
  localparam logic [3:0] SEL_INT_MAX = 4'd4;
  localparam logic [3:0] SEL_INT_MIN = 4'd5;
  localparam logic [3:0] SEL_DIF_MAX = 4'd6;
  localparam logic [3:0] SEL_DIF_MIN = 4'd7;
  localparam logic [3:0] SEL_UK_MAX  = 4'd8;
  localparam logic [3:0] SEL_UK_MIN  = 4'd9;
  localparam logic [3:0] SEL_CLEAR   = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERR,
    ST_MUL_P,
    ST_MUL_I,
    ST_MUL_D,
    ST_SAT
  } state_e;

  // Helpers work on one wide signed type so any operand width up to WIDE_W fits.
  localparam int WIDE_W = 128;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Max is applied first, then min, so an inverted range resolves to min.
  function automatic wide_t clamp_w(wide_t v, wide_t lo, wide_t hi);
    wide_t r;
    r = (v > hi) ? hi : v;
    r = (r < lo) ? lo : r;
    return r;
  endfunction

  function automatic wide_t sat_w(wide_t v, int ow);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (ow - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    return clamp_w(v, lo, hi);
  endfunction

endpackage

// File: rtl/pid_mc_core_if.sv
// rtl/pid_mc_core_if.sv - config write, sample stream and result bundle for pid_mc_core
interface pid_mc_core_if #(
  parameter int VAL_LENGTH = 32,
  parameter int CH_W       = 2
);
  logic                         cfg_we;
  logic [CH_W-1:0]              cfg_ch;
  logic [3:0]                   cfg_sel;
  logic signed [VAL_LENGTH-1:0] cfg_data;
  logic                         cfg_ready;

  logic                         sample_valid;
  logic [CH_W-1:0]              sample_ch;
  logic signed [VAL_LENGTH-1:0] current_value;
  logic                         sample_ready;

  logic                         out_valid;
  logic [CH_W-1:0]              out_ch;
  logic signed [VAL_LENGTH-1:0] pid_out;

  modport master (
    output cfg_we, cfg_ch, cfg_sel, cfg_data,
    output sample_valid, sample_ch, current_value,
    input  cfg_ready, sample_ready, out_valid, out_ch, pid_out
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_sel, cfg_data,
    input  sample_valid, sample_ch, current_value,
    output cfg_ready, sample_ready, out_valid, out_ch, pid_out
  );
endinterface

// File: rtl/pid_sat.sv
// rtl/pid_sat.sv - signed clamp to [lo_i, hi_i] followed by saturation to OW bits
module pid_sat
  import pid_mc_pkg::*;
#(
  parameter int IW = 33,
  parameter int OW = 32
) (
  input  logic signed [IW-1:0] val_i,
  input  logic signed [IW-1:0] lo_i,
  input  logic signed [IW-1:0] hi_i,
  output logic signed [OW-1:0] res_o
);

  always_comb begin
    res_o = OW'(sat_w(clamp_w(wide_t'(val_i), wide_t'(lo_i), wide_t'(hi_i)), OW));
  end

endmodule

// File: rtl/pid_mc_core.sv
// rtl/pid_mc_core.sv - time-multiplexed multi-channel PID with one shared multiplier
module pid_mc_core
  import pid_mc_pkg::*;
#(
  parameter int VAL_LENGTH = 32,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int FRAC_BITS  = 8
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  pid_mc_core_if.slave  pid_bus
);

  localparam int V     = VAL_LENGTH;
  localparam int NSLOT = 1 << CH_W;
  localparam int ACC_W = 2 * V + 2;
  localparam logic signed [V:0] VMIN1 = {2'b11, {(V-1){1'b0}}};
  localparam logic signed [V:0] VMAX1 = {2'b00, {(V-1){1'b1}}};

  typedef logic signed [V-1:0] val_t;

  // Slots beyond NUM_CH are never written and stay at reset value.
  val_t target_q  [NSLOT];
  val_t kp_q      [NSLOT];
  val_t ki_q      [NSLOT];
  val_t kd_q      [NSLOT];
  val_t int_max_q [NSLOT];
  val_t int_min_q [NSLOT];
  val_t dif_max_q [NSLOT];
  val_t dif_min_q [NSLOT];
  val_t uk_max_q  [NSLOT];
  val_t uk_min_q  [NSLOT];
  val_t integ_q   [NSLOT];
  val_t eprev_q   [NSLOT];

  state_e                   state_q, state_d;
  logic [CH_W-1:0]          ch_q;
  val_t                     cur_q, e_q, integn_q, dif_q;
  logic signed [ACC_W-1:0]  acc_q;
  val_t                     pid_out_q;
  logic [CH_W-1:0]          out_ch_q;
  logic                     out_valid_q;

  logic idle, cfg_fire, smp_fire, smp_ch_ok, cfg_ch_ok;

  assign idle      = (state_q == ST_IDLE);
  assign cfg_fire  = idle && pid_bus.cfg_we;
  assign smp_fire  = pid_bus.sample_ready && pid_bus.sample_valid;
  assign smp_ch_ok = int'(pid_bus.sample_ch) < NUM_CH;
  assign cfg_ch_ok = int'(pid_bus.cfg_ch) < NUM_CH;

  assign pid_bus.cfg_ready    = idle;
  assign pid_bus.sample_ready = idle && !pid_bus.cfg_we;
  assign pid_bus.out_valid    = out_valid_q;
  assign pid_bus.out_ch       = out_ch_q;
  assign pid_bus.pid_out      = pid_out_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (smp_fire && smp_ch_ok) state_d = ST_ERR;
      ST_ERR:   state_d = ST_MUL_P;
      ST_MUL_P: state_d = ST_MUL_I;
      ST_MUL_I: state_d = ST_MUL_D;
      ST_MUL_D: state_d = ST_SAT;
      ST_SAT:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Error path: differences formed one bit wider, saturated, then clamped.
  logic signed [V:0] e_raw, isum_raw, dsum_raw;
  val_t e_c, isum_c, integn_c, dsum_c, dif_c, uk_c;

  assign e_raw = (V+1)'(target_q[ch_q]) - (V+1)'(cur_q);
  pid_sat #(.IW(V+1), .OW(V)) u_sat_e (.val_i(e_raw), .lo_i(VMIN1), .hi_i(VMAX1), .res_o(e_c));

  assign isum_raw = (V+1)'(integ_q[ch_q]) + (V+1)'(e_c);
  pid_sat #(.IW(V+1), .OW(V)) u_sat_isum (.val_i(isum_raw), .lo_i(VMIN1), .hi_i(VMAX1), .res_o(isum_c));
  pid_sat #(.IW(V), .OW(V)) u_clamp_int (
    .val_i(isum_c), .lo_i(int_min_q[ch_q]), .hi_i(int_max_q[ch_q]), .res_o(integn_c)
  );

  assign dsum_raw = (V+1)'(e_c) - (V+1)'(eprev_q[ch_q]);
  pid_sat #(.IW(V+1), .OW(V)) u_sat_dsum (.val_i(dsum_raw), .lo_i(VMIN1), .hi_i(VMAX1), .res_o(dsum_c));
  pid_sat #(.IW(V), .OW(V)) u_clamp_dif (
    .val_i(dsum_c), .lo_i(dif_min_q[ch_q]), .hi_i(dif_max_q[ch_q]), .res_o(dif_c)
  );

  // Shared multiplier: operand pair chosen by the current MUL_* state.
  val_t kx_c, op_c;
  logic signed [2*V-1:0] prod_c;

  always_comb begin
    kx_c = kp_q[ch_q];
    op_c = e_q;
    case (state_q)
      ST_MUL_I: begin kx_c = ki_q[ch_q]; op_c = integn_q; end
      ST_MUL_D: begin kx_c = kd_q[ch_q]; op_c = dif_q;    end
      default:  ;
    endcase
    prod_c = (2*V)'(kx_c) * (2*V)'(op_c);
  end

  logic signed [ACC_W-1:0] acc_shift;
  assign acc_shift = acc_q >>> FRAC_BITS;
  pid_sat #(.IW(ACC_W), .OW(V)) u_clamp_uk (
    .val_i(acc_shift), .lo_i(ACC_W'(uk_min_q[ch_q])), .hi_i(ACC_W'(uk_max_q[ch_q])), .res_o(uk_c)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ch_q        <= '0;
      cur_q       <= '0;
      e_q         <= '0;
      integn_q    <= '0;
      dif_q       <= '0;
      acc_q       <= '0;
      pid_out_q   <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (smp_fire) begin
          ch_q  <= pid_bus.sample_ch;
          cur_q <= pid_bus.current_value;
        end
        ST_ERR: begin
          e_q      <= e_c;
          integn_q <= integn_c;
          dif_q    <= dif_c;
          acc_q    <= '0;
        end
        ST_MUL_P, ST_MUL_I, ST_MUL_D: acc_q <= acc_q + ACC_W'(prod_c);
        ST_SAT: begin
          pid_out_q   <= uk_c;
          out_ch_q    <= ch_q;
          out_valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NSLOT; i++) begin
        target_q[i]  <= '0;
        kp_q[i]      <= '0;
        ki_q[i]      <= '0;
        kd_q[i]      <= '0;
        int_max_q[i] <= '0;
        int_min_q[i] <= '0;
        dif_max_q[i] <= '0;
        dif_min_q[i] <= '0;
        uk_max_q[i]  <= '0;
        uk_min_q[i]  <= '0;
        integ_q[i]   <= '0;
        eprev_q[i]   <= '0;
      end
    end else begin
      if (cfg_fire && cfg_ch_ok) begin
        case (pid_bus.cfg_sel)
          SEL_TARGET:  target_q[pid_bus.cfg_ch]  <= pid_bus.cfg_data;
          SEL_KP:      kp_q[pid_bus.cfg_ch]      <= pid_bus.cfg_data;
          SEL_KI:      ki_q[pid_bus.cfg_ch]      <= pid_bus.cfg_data;
          SEL_KD:      kd_q[pid_bus.cfg_ch]      <= pid_bus.cfg_data;
          SEL_INT_MAX: int_max_q[pid_bus.cfg_ch] <= pid_bus.cfg_data;
          SEL_INT_MIN: int_min_q[pid_bus.cfg_ch] <= pid_bus.cfg_data;
          SEL_DIF_MAX: dif_max_q[pid_bus.cfg_ch] <= pid_bus.cfg_data;
          SEL_DIF_MIN: dif_min_q[pid_bus.cfg_ch] <= pid_bus.cfg_data;
          SEL_UK_MAX:  uk_max_q[pid_bus.cfg_ch]  <= pid_bus.cfg_data;
          SEL_UK_MIN:  uk_min_q[pid_bus.cfg_ch]  <= pid_bus.cfg_data;
          SEL_CLEAR: begin
            integ_q[pid_bus.cfg_ch] <= '0;
            eprev_q[pid_bus.cfg_ch] <= '0;
          end
          default: ;
        endcase
      end
      // Config writes only land in IDLE, so they never collide with this write-back.
      if (state_q == ST_ERR) begin
        integ_q[ch_q] <= integn_c;
        eprev_q[ch_q] <= e_c;
      end
    end
  end

endmodule

// File: tb/tb_pid_mc_core.sv
// tb/tb_pid_mc_core.sv - directed self-checking bench for pid_mc_core
module tb_pid_mc_core;

  localparam int V  = 32;
  localparam int NC = 4;
  localparam int CW = 3;
  localparam int FB = 8;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  always #5 sys_clk = ~sys_clk;

  pid_mc_core_if #(.VAL_LENGTH(V), .CH_W(CW)) bus ();

  pid_mc_core #(.VAL_LENGTH(V), .NUM_CH(NC), .CH_W(CW), .FRAC_BITS(FB)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .pid_bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cfg_write(input int ch, input int sel, input logic signed [31:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = CW'(ch);
    bus.cfg_sel  = 4'(sel);
    bus.cfg_data = d;
    for (int k = 0; k < 20 && !bus.cfg_ready; k++) tick();
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic set_uk(input int ch);
    cfg_write(ch, 8, 5000);
    cfg_write(ch, 9, -5000);
  endtask

  // Called right after the accepting edge: expects the pulse 5 edges later.
  task automatic wait_result(input string tag, input int ch, input logic signed [31:0] exp);
    int lat;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    expect_eq({tag, "_lat"}, lat, 5);
    expect_eq({tag, "_out"}, bus.pid_out, exp);
    expect_eq({tag, "_ch"}, bus.out_ch, ch);
    tick();
    expect_eq({tag, "_pulse"}, bus.out_valid, 0);
  endtask

  task automatic run_sample(input string tag, input int ch, input logic signed [31:0] cur,
                            input logic signed [31:0] exp);
    bus.sample_valid  = 1'b1;
    bus.sample_ch     = CW'(ch);
    bus.current_value = cur;
    #1;
    for (int k = 0; k < 20 && !bus.sample_ready; k++) tick();
    tick();
    bus.sample_valid = 1'b0;
    wait_result(tag, ch, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_sel = '0; bus.cfg_data = '0;
    bus.sample_valid = 1'b0; bus.sample_ch = '0; bus.current_value = '0;
    sys_rst_n = 1'b1;
    #2 sys_rst_n = 1'b0;
    repeat (3) tick();
    sys_rst_n = 1'b1;
    tick();
    expect_eq("rst_out_valid", bus.out_valid, 0);
    expect_eq("rst_pid_out", bus.pid_out, 0);
    expect_eq("rst_out_ch", bus.out_ch, 0);
    expect_eq("rst_sample_ready", bus.sample_ready, 1);

    // Proportional on ch0
    cfg_write(0, 0, 1357);
    cfg_write(0, 1, 256);
    set_uk(0);
    run_sample("p0", 0, 1000, 357);
    cfg_write(0, 9, 500);
    run_sample("p0_ukmin", 0, 1000, 500);

    // Integral windup on ch1
    cfg_write(1, 2, 768);
    cfg_write(1, 4, 50);
    cfg_write(1, 5, -50);
    cfg_write(1, 0, 100);
    set_uk(1);
    run_sample("i1_a", 1, 0, 150);
    run_sample("i1_b", 1, 0, 150);
    run_sample("i1_c", 1, 0, 150);
    cfg_write(1, 15, 0);
    run_sample("i1_clr", 1, 130, -90);

    // Derivative on ch2
    cfg_write(2, 3, 512);
    cfg_write(2, 6, 20);
    cfg_write(2, 7, -20);
    cfg_write(2, 0, 0);
    set_uk(2);
    run_sample("d2_a", 2, 0, 0);
    run_sample("d2_b", 2, -5, 10);
    run_sample("d2_c", 2, -100, 40);

    // Isolation between ch1 and ch3
    cfg_write(3, 2, 256);
    cfg_write(3, 4, 1000);
    cfg_write(3, 5, -1000);
    cfg_write(3, 0, 10);
    set_uk(3);
    run_sample("iso3_a", 3, 0, 10);
    run_sample("iso1_a", 1, 130, -150);
    run_sample("iso3_b", 3, 0, 20);
    run_sample("iso1_b", 1, 0, 150);

    // Config and sample together: config wins, sample follows
    bus.cfg_we = 1'b1; bus.cfg_ch = 3'd3; bus.cfg_sel = 4'd0; bus.cfg_data = 20;
    bus.sample_valid = 1'b1; bus.sample_ch = 3'd3; bus.current_value = 0;
    #1;
    expect_eq("col_sample_ready", bus.sample_ready, 0);
    expect_eq("col_cfg_ready", bus.cfg_ready, 1);
    tick();
    bus.cfg_we = 1'b0;
    #1;
    expect_eq("col_ready_after", bus.sample_ready, 1);
    tick();
    bus.sample_valid = 1'b0;
    wait_result("col", 3, 40);

    // Sample held through a busy period
    bus.sample_valid = 1'b1; bus.sample_ch = 3'd3; bus.current_value = 10;
    #1;
    tick();
    tick();
    expect_eq("busy_sample_ready", bus.sample_ready, 0);
    expect_eq("busy_cfg_ready", bus.cfg_ready, 0);
    cnt = 0;
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (bus.out_valid) begin
        cnt = k;
        break;
      end
    end
    expect_eq("held1_lat", cnt, 5);
    expect_eq("held1_out", bus.pid_out, 50);
    tick();
    bus.sample_valid = 1'b0;
    expect_eq("held2_busy", bus.sample_ready, 0);
    wait_result("held2", 3, 60);

    // Floor rounding and inverted uk limits on ch0
    cfg_write(0, 1, 128);
    cfg_write(0, 0, 0);
    cfg_write(0, 9, -5000);
    run_sample("rnd0", 0, 3, -2);
    cfg_write(0, 9, 10);
    cfg_write(0, 8, 5);
    run_sample("inv0", 0, 3, 10);

    // Out-of-range channel is swallowed
    bus.sample_valid = 1'b1; bus.sample_ch = CW'(NC); bus.current_value = 0;
    #1;
    expect_eq("badch_ready", bus.sample_ready, 1);
    tick();
    bus.sample_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.out_valid) cnt++;
    end
    expect_eq("badch_no_pulse", cnt, 0);
    expect_eq("badch_idle", bus.sample_ready, 1);

    // Reset in the middle of a computation
    bus.sample_valid = 1'b1; bus.sample_ch = 3'd1; bus.current_value = 0;
    #1;
    tick();
    bus.sample_valid = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b0;
    #1;
    expect_eq("mid_rst_pid_out", bus.pid_out, 0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.out_valid) cnt++;
    end
    sys_rst_n = 1'b1;
    tick();
    expect_eq("mid_rst_ready", bus.sample_ready, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.out_valid) cnt++;
    end
    expect_eq("mid_rst_no_pulse", cnt, 0);
    cfg_write(1, 2, 768);
    cfg_write(1, 4, 1000);
    cfg_write(1, 5, -1000);
    cfg_write(1, 0, 100);
    set_uk(1);
    run_sample("rst_integ_clear", 1, 0, 300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
